// File: rtl/vc_wrr_arbiter.sv
// Weighted round-robin scheduler moving words from two VC FIFOs into two destination FIFOs.
// Latency: pop is combinational, push (data_out/D*_wr) follows one cycle later; IDLE entry costs one bubble.
// Backpressure: a VC is served only while its head word's destination FIFO is not almost-full.
module vc_wrr_arbiter #(
    parameter int BW = 6,
    parameter int WW = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          active,
    input  logic [WW-1:0] weight_vc0,
    input  logic [WW-1:0] weight_vc1,
    input  logic          VC0_empty,
    input  logic          VC1_empty,
    input  logic [BW-1:0] VC0_data,
    input  logic [BW-1:0] VC1_data,
    input  logic          D0_almost_full,
    input  logic          D1_almost_full,
    output logic          VC0_rd,
    output logic          VC1_rd,
    output logic          D0_wr,
    output logic          D1_wr,
    output logic [BW-1:0] data_out,
    output logic [1:0]    grant,
    output logic [CW-1:0] vc0_count,
    output logic [CW-1:0] vc1_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERV0 = 2'd1,
        SERV1 = 2'd2
    } state_t;

    state_t        state;
    logic [WW-1:0] credit;
    logic          last_served;   // 0 = VC0 served last, 1 = VC1 served last

    logic          elig0;
    logic          elig1;
    logic [WW-1:0] wt0;
    logic [WW-1:0] wt1;
    logic          pop;
    logic [BW-1:0] pop_word;

    // A VC may go only when active, non-empty and its head's destination has room.
    assign elig0 = active & ~VC0_empty & ~(VC0_data[BW-2] ? D1_almost_full : D0_almost_full);
    assign elig1 = active & ~VC1_empty & ~(VC1_data[BW-2] ? D1_almost_full : D0_almost_full);

    // A zero weight would starve a VC forever, so it is promoted to one word per turn.
    assign wt0 = (weight_vc0 == '0) ? WW'(1) : weight_vc0;
    assign wt1 = (weight_vc1 == '0) ? WW'(1) : weight_vc1;

    assign VC0_rd   = (state == SERV0) & elig0;
    assign VC1_rd   = (state == SERV1) & elig1;
    assign pop      = VC0_rd | VC1_rd;
    assign pop_word = VC1_rd ? VC1_data : VC0_data;

    // Owner is decoded straight from the state register, so grant is glitch-free.
    assign grant = {state == SERV1, state == SERV0};

    // Push register stage: forward the popped word to the destination selected by its dest bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            D0_wr     <= 1'b0;
            D1_wr     <= 1'b0;
            data_out  <= '0;
            vc0_count <= '0;
            vc1_count <= '0;
        end else begin
            D0_wr <= pop & ~pop_word[BW-2];
            D1_wr <= pop &  pop_word[BW-2];
            if (pop) begin
                data_out <= pop_word;
            end
            if (VC0_rd) begin
                vc0_count <= vc0_count + CW'(1);
            end
            if (VC1_rd) begin
                vc1_count <= vc1_count + CW'(1);
            end
        end
    end

    // Turn-ownership FSM: credit counts words left in the current turn.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            credit      <= '0;
            last_served <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (elig0 & (last_served | ~elig1)) begin
                        state  <= SERV0;
                        credit <= wt0;
                    end else if (elig1) begin
                        state  <= SERV1;
                        credit <= wt1;
                    end
                end
                SERV0: begin
                    if (VC0_rd) begin
                        last_served <= 1'b0;
                        if (credit <= WW'(1)) begin
                            if (elig1) begin
                                state  <= SERV1;
                                credit <= wt1;
                            end else begin
                                credit <= wt0;
                            end
                        end else begin
                            credit <= credit - WW'(1);
                        end
                    end else if (elig1) begin
                        state  <= SERV1;
                        credit <= wt1;
                    end else begin
                        state  <= IDLE;
                        credit <= '0;
                    end
                end
                SERV1: begin
                    if (VC1_rd) begin
                        last_served <= 1'b1;
                        if (credit <= WW'(1)) begin
                            if (elig0) begin
                                state  <= SERV0;
                                credit <= wt0;
                            end else begin
                                credit <= wt1;
                            end
                        end else begin
                            credit <= credit - WW'(1);
                        end
                    end else if (elig0) begin
                        state  <= SERV0;
                        credit <= wt0;
                    end else begin
                        state  <= IDLE;
                        credit <= '0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    credit <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vc_wrr_arbiter.sv
// Bench for vc_wrr_arbiter: VC FIFOs modelled as queues, outputs compared each cycle to a turn/credit model.
// Latency: model predicts pops in the same cycle and pushes one cycle later.
// Backpressure: almost-full inputs are driven directly; the destination FIFOs are not modelled.
module tb_vc_wrr_arbiter;

    localparam int BW = 6;
    localparam int WW = 4;
    localparam int CW = 8;

    logic          clk;
    logic          reset;
    logic          active;
    logic [WW-1:0] weight_vc0;
    logic [WW-1:0] weight_vc1;
    logic          VC0_empty;
    logic          VC1_empty;
    logic [BW-1:0] VC0_data;
    logic [BW-1:0] VC1_data;
    logic          D0_almost_full;
    logic          D1_almost_full;
    logic          VC0_rd;
    logic          VC1_rd;
    logic          D0_wr;
    logic          D1_wr;
    logic [BW-1:0] data_out;
    logic [1:0]    grant;
    logic [CW-1:0] vc0_count;
    logic [CW-1:0] vc1_count;

    vc_wrr_arbiter #(.BW(BW), .WW(WW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .active(active),
        .weight_vc0(weight_vc0), .weight_vc1(weight_vc1),
        .VC0_empty(VC0_empty), .VC1_empty(VC1_empty),
        .VC0_data(VC0_data), .VC1_data(VC1_data),
        .D0_almost_full(D0_almost_full), .D1_almost_full(D1_almost_full),
        .VC0_rd(VC0_rd), .VC1_rd(VC1_rd), .D0_wr(D0_wr), .D1_wr(D1_wr),
        .data_out(data_out), .grant(grant),
        .vc0_count(vc0_count), .vc1_count(vc1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passes = 0;

    // FIFO contents of the two VCs, head at index 0.
    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];

    // Reference model: owner 0 = nobody, 1 = VC0, 2 = VC1; credit = words left in the turn.
    int            m_owner;
    int            m_credit;
    int            m_last;
    bit            m_d0wr;
    bit            m_d1wr;
    logic [BW-1:0] m_dout;
    int            m_c0;
    int            m_c1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [BW-1:0] mk(input int vc, input int dest, input int low);
        logic [BW-1:0] w;
        w = {vc[0], dest[0], low[BW-3:0]};
        return w;
    endfunction

    function automatic bit m_elig(input int v);
        logic [BW-1:0] h;
        if (v == 0) begin
            if (q0.size() == 0) return 1'b0;
            h = q0[0];
        end else begin
            if (q1.size() == 0) return 1'b0;
            h = q1[0];
        end
        return active && !(h[BW-2] ? D1_almost_full : D0_almost_full);
    endfunction

    function automatic int m_wt(input int v);
        int w;
        w = (v == 0) ? int'(weight_vc0) : int'(weight_vc1);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_credit = 0; m_last = 1;
        m_d0wr = 0; m_d1wr = 0; m_dout = '0; m_c0 = 0; m_c1 = 0;
    endtask

    task automatic drive_heads();
        VC0_empty = (q0.size() == 0);
        VC1_empty = (q1.size() == 0);
        VC0_data  = (q0.size() != 0) ? q0[0] : '0;
        VC1_data  = (q1.size() != 0) ? q1[0] : '0;
    endtask

    task automatic check_outputs(input bit e_rd0, input bit e_rd1);
        logic [1:0] g;
        g = {m_owner == 2, m_owner == 1};
        chk("vc0_rd", VC0_rd, e_rd0);
        chk("vc1_rd", VC1_rd, e_rd1);
        chk("grant", grant, g);
        chk("d0_wr", D0_wr, m_d0wr);
        chk("d1_wr", D1_wr, m_d1wr);
        chk("data_out", data_out, m_dout);
        chk("vc0_count", vc0_count, m_c0 % 256);
        chk("vc1_count", vc1_count, m_c1 % 256);
    endtask

    // One clock cycle: check current outputs, advance model across the edge, consume popped words.
    task automatic cycle();
        bit            e0, e1;
        int            served, other, x;
        logic [BW-1:0] word;
        int            n_owner, n_credit, n_last;
        drive_heads();
        #2;
        e0 = m_elig(0);
        e1 = m_elig(1);
        check_outputs(m_owner == 1 && e0, m_owner == 2 && e1);
        served = -1;
        if (m_owner == 1 && e0) served = 0;
        if (m_owner == 2 && e1) served = 1;
        word = '0;
        if (served == 0) word = q0[0];
        if (served == 1) word = q1[0];
        n_owner = m_owner; n_credit = m_credit; n_last = m_last;
        if (m_owner == 0) begin
            if (e0 && (m_last == 1 || !e1)) begin
                n_owner = 1; n_credit = m_wt(0);
            end else if (e1) begin
                n_owner = 2; n_credit = m_wt(1);
            end
        end else begin
            x = m_owner - 1;
            other = 1 - x;
            if (served == x) begin
                n_last = x;
                n_credit = m_credit - 1;
                if (n_credit == 0) begin
                    if (m_elig(other)) begin
                        n_owner = other + 1; n_credit = m_wt(other);
                    end else begin
                        n_credit = m_wt(x);
                    end
                end
            end else if (m_elig(other)) begin
                n_owner = other + 1; n_credit = m_wt(other);
            end else begin
                n_owner = 0; n_credit = 0;
            end
        end
        @(posedge clk);
        #1;
        m_owner = n_owner; m_credit = n_credit; m_last = n_last;
        m_d0wr = (served >= 0) && !word[BW-2];
        m_d1wr = (served >= 0) && word[BW-2];
        if (served >= 0) m_dout = word;
        if (served == 0) begin m_c0++; void'(q0.pop_front()); end
        if (served == 1) begin m_c1++; void'(q1.pop_front()); end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            model_reset();
            drive_heads();
            #2;
            check_outputs(1'b0, 1'b0);
        end
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset = 1'b1; active = 1'b0;
        weight_vc0 = 4'd1; weight_vc1 = 4'd1;
        D0_almost_full = 1'b0; D1_almost_full = 1'b0;
        model_reset();
        drive_heads();

        // Reset held with both VCs non-empty and active high.
        for (int i = 0; i < 3; i++) begin q0.push_back(mk(0, 0, i)); q1.push_back(mk(1, 1, i)); end
        active = 1'b1;
        do_reset();

        // Weights 2/1, six D0-bound words per VC.
        q0.delete(); q1.delete();
        for (int i = 0; i < 6; i++) begin q0.push_back(mk(0, 0, i)); q1.push_back(mk(1, 0, i + 8)); end
        weight_vc0 = 4'd2; weight_vc1 = 4'd1;
        do_reset();
        run(7);
        chk("wrr_2_1_vc0_after6", vc0_count, 4);
        chk("wrr_2_1_vc1_after6", vc1_count, 2);
        run(8);

        // Only VC1, alternating destinations, weight 1.
        q0.delete(); q1.delete();
        for (int i = 0; i < 4; i++) q1.push_back(mk(1, i % 2, i + 3));
        weight_vc1 = 4'd1;
        do_reset();
        run(8);

        // D1 almost-full blocks VC0 (dest D1) while VC1 (dest D0) drains; then release.
        q0.delete(); q1.delete();
        for (int i = 0; i < 3; i++) begin q0.push_back(mk(0, 1, i)); q1.push_back(mk(1, 0, i)); end
        weight_vc0 = 4'd1; weight_vc1 = 4'd1;
        D1_almost_full = 1'b1;
        do_reset();
        run(8);
        chk("blocked_vc0_untouched", vc0_count, 0);
        D1_almost_full = 1'b0;
        run(6);

        // active drops after the third pop of a weight-4 VC0 turn, then returns.
        q0.delete(); q1.delete();
        for (int i = 0; i < 10; i++) q0.push_back(mk(0, 0, i));
        weight_vc0 = 4'd4;
        do_reset();
        run(4);
        active = 1'b0;
        run(3);
        chk("active_drop_pushes", vc0_count, 3);
        active = 1'b1;
        run(9);

        // Zero weights promote to one: strict alternation.
        q0.delete(); q1.delete();
        for (int i = 0; i < 5; i++) begin q0.push_back(mk(0, 0, i)); q1.push_back(mk(1, 1, i)); end
        weight_vc0 = 4'd0; weight_vc1 = 4'd0;
        do_reset();
        run(13);

        // 256 VC0 words wrap the counter back to zero.
        q0.delete(); q1.delete();
        for (int i = 0; i < 256; i++) q0.push_back(mk(0, i % 2, i));
        do_reset();
        run(260);
        chk("vc0_count_wrap", vc0_count, 0);

        // Randomized traffic, weights, backpressure and active, with one reset mid-run.
        q0.delete(); q1.delete();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) begin
                weight_vc0 = 4'($urandom_range(0, 5));
                weight_vc1 = 4'($urandom_range(0, 5));
            end
            if (q0.size() < 8 && $urandom_range(0, 2) != 0) q0.push_back(mk(0, $urandom_range(0, 1), $urandom_range(0, 15)));
            if (q1.size() < 8 && $urandom_range(0, 2) != 0) q1.push_back(mk(1, $urandom_range(0, 1), $urandom_range(0, 15)));
            D0_almost_full = ($urandom_range(0, 4) == 0);
            D1_almost_full = ($urandom_range(0, 4) == 0);
            active = ($urandom_range(0, 15) != 0);
            if (n == 1500) do_reset();
            cycle();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/vc_wrr_arbiter.md
Name: vc_wrr_arbiter

Overview:
- Weighted round-robin scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) in the PCIe QoS datapath.
- Pops one word per cycle from the granted VC FIFO. Routes it by its destination bit into D0 or D1, registered.
- Respects per-destination almost-full backpressure. Only runs while the main control FSM reports active.

Parameters:
BW, 6, data word width; bit BW-1 = VC class, bit BW-2 = destination select (0 → D0, 1 → D1)
WW, 4, width of weight inputs and credit counter
CW, 8, width of forwarded-word counters

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
active  input  1  main control FSM in ACTIVE state; arbitration enabled
weight_vc0  input  WW  VC0 words per turn (0 treated as 1)
weight_vc1  input  WW  VC1 words per turn (0 treated as 1)
VC0_empty  input  1  VC0 FIFO empty
VC1_empty  input  1  VC1 FIFO empty
VC0_data  input  BW  VC0 head word (show-ahead)
VC1_data  input  BW  VC1 head word (show-ahead)
D0_almost_full  input  1  D0 at/above high threshold
D1_almost_full  input  1  D1 at/above high threshold
VC0_rd  output  1  pop VC0 (combinational)
VC1_rd  output  1  pop VC1 (combinational)
D0_wr  output  1  push D0 (registered)
D1_wr  output  1  push D1 (registered)
data_out  output  BW  word pushed to D0/D1 (registered)
grant  output  2  one-hot current owner {VC1,VC0}; 00 in IDLE
vc0_count  output  CW  words forwarded from VC0, wraps
vc1_count  output  CW  words forwarded from VC1, wraps

Behaviour:
- Reset (reset=1 at clk edge):
  - state=IDLE, credit=0, last_served=VC1 (VC0 wins first tie).
  - D0_wr=D1_wr=0, data_out=0, grant=00, counters=0.
  - A push pending from the prior cycle is dropped.
- Eligibility (combinational):
  - eligX = active & ~VCX_empty & ~(dest(VCX_data) ? D1_almost_full : D0_almost_full).
- States: IDLE, SERV0, SERV1. grant reflects the state.
- IDLE:
  - No pops.
  - If elig0 & (last_served==VC1 | ~elig1) → SERV0, credit←max(weight_vc0,1).
  - Else if elig1 → SERV1, credit←max(weight_vc1,1).
  - Else stay IDLE.
  - Entering from IDLE costs one bubble cycle.
- SERVX:
  - VCX_rd = eligX; the other rd = 0.
  - On pop: credit←credit-1, last_served←X.
  - Pop with credit==1:
    - If other eligible → SERVother, credit←weight_other.
    - Else stay SERVX, credit←weightX (no idle penalty).
  - No pop (~eligX):
    - If other eligible → SERVother, credit←weight_other, with no bubble.
    - Else → IDLE.
  - Pop with credit>1: stay.
- Weights are sampled only when credit is loaded. Changing weights mid-turn affects the next turn only.
- Push path, latency 1 cycle:
  - On a pop, at the next edge: data_out←popped word, D0_wr←~dest, D1_wr←dest, vcX_count←vcX_count+1 (mod 2^CW).
  - With no pop, D0_wr=D1_wr=0 and data_out holds its value.
- Never pops both VCs in one cycle. Never pushes both D FIFOs in one cycle.
- Backpressure: no compensation for the in-flight push. D almost-full thresholds must leave ≥2 free entries.
- Head word destination blocked while the other VC is eligible: the turn passes immediately (head-of-line avoidance is per VC only).
- active falling mid-turn: no further pops. Next edge → IDLE. The push already in flight still completes. Remaining credit is discarded.
- Reset asserted mid-operation has priority over all transitions.

Test Plan:
- Reset: reset=1 for 2 cycles with VC FIFOs non-empty → all outputs 0, grant=00, no VC rd.
- Weights 2/1, both VCs hold 6 words dest D0, active=1 → pop order after 1 bubble: VC0,VC0,VC1,VC0,VC0,VC1…; D0_wr one cycle after each rd; vc0_count=4, vc1_count=2 after 6 pops.
- Only VC1 non-empty (4 words, dest alternating D0/D1), weight 1 → four consecutive VC1_rd with no gaps; pushes alternate D0_wr/D1_wr; data_out matches order.
- D1_almost_full=1, VC0 head dest D1, VC1 head dest D0 → VC0 never popped; VC1 drained. Release D1_almost_full → VC0 resumes within 2 cycles.
- active dropped after 3rd pop of a weight-4 VC0 turn → 3 pushes total; grant→00 next cycle. Re-assert active → new full turn (credit reload), bubble of 1 cycle.
- Weights 0/0 → treated as 1/1; strict alternation VC0,VC1; counter wrap: 256 VC0 words → vc0_count returns to 0.
